// File: rtl/qchannel_pwr_ctrl_if.sv
// -----------------------------------------------------------------------------
// qchannel_pwr_ctrl_if
//
// Q-channel handshake bundle between a power controller and a Q-channel device.
//
// Signals:
//   qreqn     Q-channel request, active-low. The controller drives it.
//   qacceptn  Device accept, active-low. The device drives it.
//   qdeny     Device deny, active-high. The device drives it.
//
// Modports:
//   master    The controller (initiator). It drives qreqn.
//   slave     The device. It drives qacceptn and qdeny.
// -----------------------------------------------------------------------------
interface qchannel_pwr_ctrl_if;
    logic qreqn;
    logic qacceptn;
    logic qdeny;

    modport master (
        output qreqn,
        input  qacceptn,
        input  qdeny
    );

    modport slave (
        input  qreqn,
        output qacceptn,
        output qdeny
    );
endinterface

// File: rtl/qchannel_pwr_ctrl.sv
// -----------------------------------------------------------------------------
// qchannel_pwr_ctrl
//
// Always-on Q-channel initiator. It turns the system power manager's
// sleep/wake levels into the Q-channel handshake with one device. It holds the
// device powered off for at least MIN_OFF cycles. It then issues a one-cycle
// retention-restore strobe before it releases the quiescence request.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous reset, active-low
//   sleep_req    power manager requests low power (level)
//   wake_req     power manager requests wake-up (level)
//   q_if         Q-channel handshake (master side): qreqn out; qacceptn and
//                qdeny in
//   pr_restore   one-cycle retention restore strobe
//   pwr_off      power-switch / isolation enable
//   state_o      current FSM state
//   denied_o     one-cycle pulse when the device denies a request
//   timeout_o    one-cycle pulse when a request has waited TIMEOUT cycles
//   proto_err_o  sticky flag for an illegal device response
//
// All outputs are registered. A decision made on the inputs sampled at a clock
// edge becomes visible immediately after that edge.
// -----------------------------------------------------------------------------
module qchannel_pwr_ctrl #(
    parameter int unsigned MIN_OFF = 4,
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       sleep_req,
    input  logic                       wake_req,
    qchannel_pwr_ctrl_if.master        q_if,
    output logic                       pr_restore,
    output logic                       pwr_off,
    output logic [2:0]                 state_o,
    output logic                       denied_o,
    output logic                       timeout_o,
    output logic                       proto_err_o
);

    localparam logic [2:0] ST_RUN      = 3'd0;
    localparam logic [2:0] ST_REQUEST  = 3'd1;
    localparam logic [2:0] ST_STOPPED  = 3'd2;
    localparam logic [2:0] ST_RESTORE  = 3'd3;
    localparam logic [2:0] ST_EXIT     = 3'd4;
    localparam logic [2:0] ST_DENIED   = 3'd5;
    localparam logic [2:0] ST_CONTINUE = 3'd6;

    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] WAKE_AT    = CNT_W'(MIN_OFF - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(TIMEOUT);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qreqn_q, qreqn_d;
    logic             pr_restore_q, pr_restore_d;
    logic             pwr_off_q, pwr_off_d;
    logic             denied_q, denied_d;
    logic             timeout_q, timeout_d;
    logic             proto_err_q, proto_err_d;

    // NOTE: every signal written here gets a default before the case. Any
    // path that leaves a signal unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        proto_err_d = proto_err_q;
        denied_d    = 1'b0;

        case (state_q)
            ST_RUN: begin
                // qreqn may only fall while the device shows (accept=1, deny=0).
                if (sleep_req && q_if.qacceptn && !q_if.qdeny)
                    state_d = ST_REQUEST;
            end
            ST_REQUEST: begin
                // Accept wins over a simultaneous deny. The accept+deny
                // combination is illegal, so it is flagged.
                if (!q_if.qacceptn) begin
                    state_d = ST_STOPPED;
                    if (q_if.qdeny)
                        proto_err_d = 1'b1;
                end else if (q_if.qdeny) begin
                    state_d  = ST_DENIED;
                    denied_d = 1'b1;
                end
            end
            ST_STOPPED: begin
                // A device that leaves the stopped handshake is misbehaving.
                // Stay powered off rather than restore into unknown state.
                if (q_if.qacceptn || q_if.qdeny)
                    proto_err_d = 1'b1;
                else if (wake_req && cnt_q >= WAKE_AT)
                    state_d = ST_RESTORE;
            end
            ST_RESTORE: begin
                state_d = ST_EXIT;
            end
            ST_EXIT: begin
                if (q_if.qdeny)
                    proto_err_d = 1'b1;
                if (q_if.qacceptn)
                    state_d = ST_RUN;
            end
            ST_DENIED: begin
                // qreqn may rise only once qacceptn == qdeny.
                if (q_if.qacceptn && q_if.qdeny)
                    state_d = ST_CONTINUE;
            end
            ST_CONTINUE: begin
                if (!q_if.qdeny)
                    state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // The shared counter clears on every state change. It advances only
        // in the two timed states, and it saturates instead of wrapping.
        if (state_d != state_q)
            cnt_d = '0;
        else if ((state_q == ST_REQUEST || state_q == ST_STOPPED) && cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_ONE;
        else
            cnt_d = cnt_q;

        // Pulse in the cycle the counter first holds TIMEOUT. The second term
        // stops a counter saturated at TIMEOUT from pulsing again.
        timeout_d = (state_q == ST_REQUEST) && (state_d == ST_REQUEST) &&
                    (cnt_d == TIMEOUT_AT) && (cnt_q != TIMEOUT_AT);

        // The registered outputs are decoded from the next state. They then
        // change on the same edge as the state register.
        qreqn_d      = !(state_d == ST_REQUEST || state_d == ST_STOPPED ||
                         state_d == ST_RESTORE || state_d == ST_DENIED);
        pwr_off_d    = (state_d == ST_STOPPED);
        pr_restore_d = (state_d == ST_RESTORE);
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples pre-edge values, whatever order the blocks run in.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            qreqn_q      <= 1'b1;
            pr_restore_q <= 1'b0;
            pwr_off_q    <= 1'b0;
            denied_q     <= 1'b0;
            timeout_q    <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            qreqn_q      <= qreqn_d;
            pr_restore_q <= pr_restore_d;
            pwr_off_q    <= pwr_off_d;
            denied_q     <= denied_d;
            timeout_q    <= timeout_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign q_if.qreqn  = qreqn_q;
    assign pr_restore  = pr_restore_q;
    assign pwr_off     = pwr_off_q;
    assign state_o     = state_q;
    assign denied_o    = denied_q;
    assign timeout_o   = timeout_q;
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_qchannel_pwr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_qchannel_pwr_ctrl
//
// Self-checking bench for qchannel_pwr_ctrl. A behavioural model advances on
// every rising edge. It tracks which phase of the handshake the controller is
// in and how many cycles it has spent there, as an unbounded integer. From
// that it predicts every output. A compare process checks the DUT against the
// model on every falling edge. Directed sequences pin key cycles to
// hand-computed literals. Randomised device/power-manager traffic follows.
// A 4-bit counter makes saturation reachable within a short run.
// -----------------------------------------------------------------------------
module tb_qchannel_pwr_ctrl;

    localparam int MIN_OFF = 4;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       sleep_req;
    logic       wake_req;
    logic       pr_restore;
    logic       pwr_off;
    logic [2:0] state_o;
    logic       denied_o;
    logic       timeout_o;
    logic       proto_err_o;

    qchannel_pwr_ctrl_if qif ();

    qchannel_pwr_ctrl #(
        .MIN_OFF (MIN_OFF),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sleep_req   (sleep_req),
        .wake_req    (wake_req),
        .q_if        (qif),
        .pr_restore  (pr_restore),
        .pwr_off     (pwr_off),
        .state_o     (state_o),
        .denied_o    (denied_o),
        .timeout_o   (timeout_o),
        .proto_err_o (proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase numbers are the visible state_o codes:
    // RUN=0 REQUEST=1 STOPPED=2 RESTORE=3 EXIT=4 DENIED=5 CONTINUE=6.
    int m_phase = 0;
    int m_age   = 0;   // cycles spent in the current phase, unbounded
    bit m_err   = 0;
    bit m_den   = 0;
    bit m_to    = 0;
    bit inv_armed = 0;

    task automatic model_step(input bit rst, input bit slp, input bit wak,
                              input bit acc, input bit dny);
        int nxt;
        if (!rst) begin
            m_phase = 0; m_age = 0; m_err = 0; m_den = 0; m_to = 0;
            return;
        end
        nxt   = m_phase;
        m_den = 0;
        case (m_phase)
            0: if (slp && acc && !dny) nxt = 1;
            1: begin
                if (!acc) begin nxt = 2; if (dny) m_err = 1; end
                else if (dny) begin nxt = 5; m_den = 1; end
            end
            2: begin
                if (acc || dny) m_err = 1;
                else if (wak && m_age >= MIN_OFF - 1) nxt = 3;
            end
            3: nxt = 4;
            4: begin if (dny) m_err = 1; if (acc) nxt = 0; end
            5: if (acc && dny) nxt = 6;
            6: if (!dny) nxt = 0;
            default: nxt = 0;
        endcase
        // The count is an unbounded integer, so TIMEOUT can be hit only once.
        m_to    = (m_phase == 1) && (nxt == 1) && (m_age + 1 == TIMEOUT);
        m_age   = (nxt != m_phase) ? 0 : m_age + 1;
        m_phase = nxt;
    endtask

    function automatic logic [8:0] model_outputs();
        logic req_low;
        req_low = (m_phase == 1) || (m_phase == 2) || (m_phase == 3) || (m_phase == 5);
        return {!req_low, m_phase == 3, m_phase == 2, 3'(m_phase), m_den, m_to, m_err};
    endfunction

    always @(posedge clk_i) begin
        // These reads see pre-edge DUT values, because DUT registers update afterwards.
        inv_armed = rst_i && !qif.qreqn && !qif.qacceptn && !pr_restore;
        model_step(rst_i, sleep_req, wake_req, qif.qacceptn, qif.qdeny);
    end

    // ---------------- compare process ----------------
    bit chk_en = 0;

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("outputs{qreqn,pr,pwr,state,den,to,err}",
                  {qif.qreqn, pr_restore, pwr_off, state_o, denied_o, timeout_o, proto_err_o},
                  model_outputs());
            if (inv_armed)
                check("qreqn_held_low", qif.qreqn, 1'b0);
        end
    end

    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        sleep_req = 0; wake_req = 0; qif.qacceptn = 1; qif.qdeny = 0;
    endtask

    // ---------------- stimulus and literal checks ----------------
    initial begin
        rst_i = 0;
        idle_inputs();
        @(posedge clk_i);
        #1 chk_en = 1;
        cyc();
        check("rst_state", state_o, 3'd0);
        check("rst_qreqn", qif.qreqn, 1'b1);
        check("rst_quiet", {pr_restore, pwr_off, denied_o, timeout_o, proto_err_o}, 5'b0);
        rst_i = 1;
        cyc();

        // Clean entry/exit with the wake held from the first STOPPED cycle.
        sleep_req = 1;                                   // cycle 0
        cyc(); check("clean_req_qreqn", qif.qreqn, 1'b0); // cycle 1
        check("clean_req_state", state_o, 3'd1);
        cyc(); cyc(); qif.qacceptn = 0;                  // cycle 3
        cyc();                                           // cycle 4
        check("clean_stop_state", state_o, 3'd2);
        sleep_req = 0; wake_req = 1;
        for (int c = 4; c <= 7; c++) begin
            check("clean_off_pwr", pwr_off, 1'b1);
            check("clean_off_pr", pr_restore, 1'b0);
            cyc();
        end
        check("clean_restore_pr", {pr_restore, pwr_off, state_o}, {1'b1, 1'b0, 3'd3}); // cycle 8
        wake_req = 0;
        cyc(); check("clean_exit", {qif.qreqn, pr_restore, state_o}, {1'b1, 1'b0, 3'd4}); // cycle 9
        cyc(); check("clean_exit_wait", state_o, 3'd4); qif.qacceptn = 1;                 // cycle 10
        cyc(); check("clean_run", {qif.qreqn, state_o}, {1'b1, 3'd0});                     // cycle 11

        // Deny path.
        sleep_req = 1;
        cyc(); qif.qdeny = 1;
        cyc(); check("deny_pulse", {denied_o, qif.qreqn, state_o}, {1'b1, 1'b0, 3'd5});
        cyc(); check("deny_cont", {denied_o, qif.qreqn, state_o}, {1'b0, 1'b1, 3'd6});
        qif.qdeny = 0; sleep_req = 0;
        cyc(); check("deny_run", {state_o, pwr_off, pr_restore}, {3'd0, 1'b0, 1'b0});

        // Timeout, then a late accept. The window runs past counter saturation.
        sleep_req = 1;
        cyc();
        for (int c = 1; c <= 30; c++) begin
            check("timeout_pulse", timeout_o, (c == 9));
            check("timeout_qreqn", qif.qreqn, 1'b0);
            if (c < 30) cyc();
        end
        qif.qacceptn = 0; sleep_req = 0;
        cyc(); check("timeout_late_accept", {pwr_off, state_o}, {1'b1, 3'd2});
        wake_req = 1;
        repeat (4) cyc();
        check("timeout_restore", pr_restore, 1'b1);
        wake_req = 0;
        cyc(); qif.qacceptn = 1;
        cyc(); check("timeout_back_run", state_o, 3'd0);

        // Protocol error (accept + deny), sticky, then reset while powered off.
        sleep_req = 1;
        cyc(); qif.qacceptn = 0; qif.qdeny = 1;
        cyc(); check("perr_set", {proto_err_o, state_o, pwr_off}, {1'b1, 3'd2, 1'b1});
        qif.qdeny = 0; sleep_req = 0;
        repeat (3) cyc();
        check("perr_sticky", {proto_err_o, pwr_off}, 2'b11);
        rst_i = 0;
        cyc();
        check("rst_mid_stop",
              {qif.qreqn, pr_restore, pwr_off, state_o, denied_o, timeout_o, proto_err_o},
              {1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});
        rst_i = 1; idle_inputs();
        cyc();

        // Randomised traffic: a mostly well-behaved device with occasional faults.
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (!qif.qreqn) begin
                case ({qif.qacceptn, qif.qdeny})
                    2'b10: if (r < 12) {qif.qacceptn, qif.qdeny} = 2'b00;
                           else if (r < 20) {qif.qacceptn, qif.qdeny} = 2'b11;
                           else if (r < 22) {qif.qacceptn, qif.qdeny} = 2'b01;
                    2'b00: if (r < 2) {qif.qacceptn, qif.qdeny} = 2'b10;
                           else if (r < 3) {qif.qacceptn, qif.qdeny} = 2'b01;
                    2'b01: if (r < 30) {qif.qacceptn, qif.qdeny} = 2'b00;
                    default: ;
                endcase
            end else if ({qif.qacceptn, qif.qdeny} != 2'b10 && r < 40) begin
                {qif.qacceptn, qif.qdeny} = 2'b10;
            end
            if ($urandom_range(0, 9) == 0) sleep_req = ~sleep_req;
            if ($urandom_range(0, 5) == 0) wake_req = ~wake_req;
            rst_i = ($urandom_range(0, 249) != 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
